// File: rtl/mesm6_alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// mesm6_alu_issue_pkg
//   Shared constants for the ALU issue block: ALU operation code width and
//   the operation codes understood by the mesm6 ALU, plus a small helper.
// ---------------------------------------------------------------------------
package mesm6_alu_issue_pkg;

    localparam int ALU_OP_WIDTH = 6;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP  = 6'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AAX  = 6'd1;  // A := A and B
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AOX  = 6'd2;  // A := A or B
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AEX  = 6'd3;  // A := A xor B
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ARX  = 6'd4;  // add with end-around carry
    localparam logic [ALU_OP_WIDTH-1:0] ALU_YTA  = 6'd5;  // A := Y
    localparam logic [ALU_OP_WIDTH-1:0] ALU_FADD = 6'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_FMUL = 6'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_FDIV = 6'd8;

    function automatic logic is_nop(input logic [ALU_OP_WIDTH-1:0] op);
        return op == ALU_NOP;
    endfunction

endpackage

// File: rtl/mesm6_alu_issue.sv
// ---------------------------------------------------------------------------
// mesm6_alu_issue
//   Initiator side of the ALU op/done protocol. Takes one request at a time
//   from the instruction sequencer, registers its operands, holds the op on
//   the ALU until done (or until TIMEOUT cycles have elapsed), returns the
//   ALU to NOP and then presents the result.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_*                   request from the sequencer (valid/ready)
//   abort                   kill the op in flight, no result is produced
//   alu_op/alu_wy/...       registered controls and operands to the ALU
//   alu_acc, alu_done       ALU result and completion
//   res_*                   result to the consumer (valid/ready)
//   state_dbg               current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready depends only on state; res_valid stays high with res_*
// stable until res_ready is seen. The producer must not retract payload
// while valid is high and ready is low.
// ---------------------------------------------------------------------------
module mesm6_alu_issue
    import mesm6_alu_issue_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CYC_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ALU_OP_WIDTH-1:0] req_op,
    input  logic                    req_wy,
    input  logic                    req_grp_log,
    input  logic                    req_norm,
    input  logic                    req_round,
    input  logic [47:0]             req_a,
    input  logic [47:0]             req_b,

    input  logic                    abort,

    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    alu_wy,
    output logic                    alu_grp_log,
    output logic                    alu_do_norm,
    output logic                    alu_do_round,
    output logic [47:0]             alu_a,
    output logic [47:0]             alu_b,
    input  logic [47:0]             alu_acc,
    input  logic                    alu_done,

    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [47:0]             res_acc,
    output logic                    res_err,
    output logic [CYC_W-1:0]        res_cycles,

    output logic [1:0]              state_dbg
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_WYPULSE = 2'd2;
    localparam logic [1:0] S_RESULT  = 2'd3;

    localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] ONE_C     = CYC_W'(1);

    logic [1:0]       state;
    logic [CYC_W-1:0] counter;

    assign req_ready = (state == S_IDLE);
    assign res_valid = (state == S_RESULT);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            counter      <= '0;
            alu_op       <= ALU_NOP;
            alu_wy       <= 1'b0;
            alu_grp_log  <= 1'b0;
            alu_do_norm  <= 1'b0;
            alu_do_round <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            res_acc      <= '0;
            res_err      <= 1'b0;
            res_cycles   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        // Operands and modifiers are captured only here, so
                        // the ALU sees them unchanged for the whole op.
                        alu_a        <= req_a;
                        alu_b        <= req_b;
                        alu_grp_log  <= req_grp_log;
                        alu_do_norm  <= req_norm;
                        alu_do_round <= req_round;
                        counter      <= ONE_C;
                        if (is_nop(req_op)) begin
                            // Y:=A is a one-cycle pulse with the op left at NOP.
                            alu_wy <= req_wy;
                            state  <= S_WYPULSE;
                        end else begin
                            alu_op <= req_op;
                            alu_wy <= 1'b0;
                            state  <= S_BUSY;
                        end
                    end
                end

                S_WYPULSE: begin
                    alu_wy <= 1'b0;
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        res_acc    <= alu_acc;
                        res_err    <= 1'b0;
                        res_cycles <= ONE_C;
                        state      <= S_RESULT;
                    end
                end

                S_BUSY: begin
                    if (abort) begin
                        alu_op <= ALU_NOP;
                        alu_wy <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        if (counter != '1) begin
                            counter <= counter + ONE_C;
                        end
                        // done is checked first: a done arriving on the
                        // timeout edge still yields a good result.
                        if (alu_done) begin
                            res_acc    <= alu_acc;
                            res_err    <= 1'b0;
                            res_cycles <= counter;
                            alu_op     <= ALU_NOP;
                            state      <= S_RESULT;
                        end else if (counter == TIMEOUT_C) begin
                            res_err    <= 1'b1;
                            res_cycles <= counter;
                            alu_op     <= ALU_NOP;
                            state      <= S_RESULT;
                        end
                    end
                end

                S_RESULT: begin
                    // alu_op is already NOP here; this state gives the ALU
                    // at least one NOP edge before the next issue.
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    alu_op <= ALU_NOP;
                    alu_wy <= 1'b0;
                end
            endcase
        end
    end

endmodule
